// File: rtl/io_port_bank.sv
// Parametrised GPIO bank on the I/O bus: per-port DDR/PORT/PIN registers,
// pin-change mask/flag/enable registers and a single interrupt request.
module io_port_bank #(
   parameter int DATA_WIDTH    = 8,
   parameter int IO_ADDR_WIDTH = 6,
   parameter int PORT_COUNT    = 4,
   parameter int BASE_ADDR     = 'h10,
   parameter int SYNC_STAGES   = 2
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             cs,
   input  logic                             we,
   input  logic                             oe,
   input  logic [IO_ADDR_WIDTH-1:0]         address,
   inout  wire  [DATA_WIDTH-1:0]            data,
   inout  wire  [PORT_COUNT*DATA_WIDTH-1:0] pins,
   output logic                             irq
);

   localparam int PW      = PORT_COUNT * DATA_WIDTH;
   localparam int CW      = $clog2(SYNC_STAGES + 2);
   localparam int A_PCIFR = 4 * PORT_COUNT;
   localparam int A_PCICR = 4 * PORT_COUNT + 1;

   if (BASE_ADDR + 3 * PORT_COUNT + PORT_COUNT + 1 >= 2 ** IO_ADDR_WIDTH) begin : g_bad_window
      $error("io_port_bank: register window exceeds the I/O address space");
   end
   if (PORT_COUNT < 1 || PORT_COUNT > 8 || PORT_COUNT > DATA_WIDTH) begin : g_bad_ports
      $error("io_port_bank: PORT_COUNT out of range");
   end
   if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
      $error("io_port_bank: SYNC_STAGES out of range");
   end

   logic [PW-1:0]         ddr, port_q, pcmsk, prev, chg, pin;
   logic [PW-1:0]         sync_q [SYNC_STAGES];
   logic [PORT_COUNT-1:0] pcifr, pcicr, pcifr_set, pcifr_clr;
   logic [CW-1:0]         warm_cnt;
   logic                  warm_done, in_win, wr_en, rd_en;
   logic [DATA_WIDTH-1:0] rd_data;
   int                    off;

   always_comb begin
      off    = int'(address) - BASE_ADDR;
      in_win = (off >= 0) && (off <= A_PCICR);
      wr_en  = cs & we & in_win;
      rd_en  = cs & oe & ~we & in_win;
   end

   assign pin       = sync_q[SYNC_STAGES-1];
   assign warm_done = (warm_cnt == CW'(SYNC_STAGES + 1));
   assign chg       = (pin ^ prev) & pcmsk;

   always_comb begin
      pcifr_set = '0;
      for (int p = 0; p < PORT_COUNT; p++)
         pcifr_set[p] = warm_done & (|chg[p*DATA_WIDTH +: DATA_WIDTH]);
      pcifr_clr = (wr_en && off == A_PCIFR) ? data[PORT_COUNT-1:0] : '0;
   end

   // Bus-writable configuration registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ddr    <= '0;
         port_q <= '0;
         pcmsk  <= '0;
         pcicr  <= '0;
      end else if (wr_en) begin
         for (int p = 0; p < PORT_COUNT; p++) begin
            if (off == 3 * p)
               port_q[p*DATA_WIDTH +: DATA_WIDTH] <= port_q[p*DATA_WIDTH +: DATA_WIDTH] ^ data;
            if (off == 3 * p + 1)
               ddr[p*DATA_WIDTH +: DATA_WIDTH] <= data;
            if (off == 3 * p + 2)
               port_q[p*DATA_WIDTH +: DATA_WIDTH] <= data;
            if (off == 3 * PORT_COUNT + p)
               pcmsk[p*DATA_WIDTH +: DATA_WIDTH] <= data;
         end
         if (off == A_PCICR)
            pcicr <= data[PORT_COUNT-1:0];
      end
   end

   // Synchroniser, change history, warm-up and flags; a set beats a same-edge clear
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int s = 0; s < SYNC_STAGES; s++)
            sync_q[s] <= '0;
         prev     <= '0;
         pcifr    <= '0;
         warm_cnt <= '0;
      end else begin
         sync_q[0] <= pins;
         for (int s = 1; s < SYNC_STAGES; s++)
            sync_q[s] <= sync_q[s-1];
         prev <= pin;
         if (!warm_done)
            warm_cnt <= warm_cnt + CW'(1);
         pcifr <= (pcifr & ~pcifr_clr) | pcifr_set;
      end
   end

   always_comb begin
      rd_data = '0;
      for (int p = 0; p < PORT_COUNT; p++) begin
         if (off == 3 * p)              rd_data = pin[p*DATA_WIDTH +: DATA_WIDTH];
         if (off == 3 * p + 1)          rd_data = ddr[p*DATA_WIDTH +: DATA_WIDTH];
         if (off == 3 * p + 2)          rd_data = port_q[p*DATA_WIDTH +: DATA_WIDTH];
         if (off == 3 * PORT_COUNT + p) rd_data = pcmsk[p*DATA_WIDTH +: DATA_WIDTH];
      end
      if (off == A_PCIFR) rd_data[PORT_COUNT-1:0] = pcifr;
      if (off == A_PCICR) rd_data[PORT_COUNT-1:0] = pcicr;
   end

   assign data = rd_en ? rd_data : 'z;
   assign irq  = |(pcifr & pcicr);

   for (genvar i = 0; i < PW; i++) begin : g_pin_drv
      assign pins[i] = ddr[i] ? port_q[i] : 1'bz;
   end

endmodule

// File: tb/tb_io_port_bank.sv
// Scoreboard bench for io_port_bank: 4 ports at 0x10, two-stage synchroniser.
// Undriven nets are pulled up, so a released bus or pin reads back as all ones.
module tb_io_port_bank;
   localparam int DW = 8;
   localparam int AW = 6;
   localparam int PC = 4;

   logic              clk = 1'b0;
   logic              reset, cs, we, oe;
   logic [AW-1:0]     address;
   logic              data_oe;
   logic [DW-1:0]     data_val;
   logic [PC*DW-1:0]  pins_oe, pins_val;
   wire  [DW-1:0]     data;
   wire  [PC*DW-1:0]  pins;
   logic              irq;

   typedef struct {
      string       name;
      logic [31:0] val;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] obs_q[$];
   int          checks = 0;
   int          passes = 0;

   assign data = data_oe ? data_val : 'z;
   for (genvar i = 0; i < DW; i++) begin : g_pu_data
      pullup (data[i]);
   end
   for (genvar i = 0; i < PC*DW; i++) begin : g_pins
      assign pins[i] = pins_oe[i] ? pins_val[i] : 1'bz;
      pullup (pins[i]);
   end

   always #5 clk = ~clk;

   io_port_bank #(
      .DATA_WIDTH(DW), .IO_ADDR_WIDTH(AW), .PORT_COUNT(PC), .BASE_ADDR('h10), .SYNC_STAGES(2)
   ) dut (
      .clk(clk), .reset(reset), .cs(cs), .we(we), .oe(oe),
      .address(address), .data(data), .pins(pins), .irq(irq)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      cs = 1'b1; we = 1'b1; oe = 1'b0; address = a; data_oe = 1'b1; data_val = d;
      tick();
      cs = 1'b0; we = 1'b0; data_oe = 1'b0;
   endtask

   task automatic rd(input logic [AW-1:0] a, output logic [DW-1:0] d);
      cs = 1'b1; oe = 1'b1; we = 1'b0; address = a;
      #1;
      d = data;
      cs = 1'b0; oe = 1'b0;
   endtask

   function automatic void expect_val(input string name, input logic [31:0] v);
      exp_t e;
      e.name = name;
      e.val  = v;
      sb_q.push_back(e);
   endfunction

   task automatic test_reset();
      logic [DW-1:0] d;
      reset = 1'b0;
      #3;
      expect_val("pins_z_in_reset", 32'hFFFF_FFFF); obs_q.push_back(pins);
      expect_val("irq_in_reset", 32'h0);            obs_q.push_back({31'h0, irq});
      pins_oe = '1; pins_val = '0;
      repeat (2) @(posedge clk);
      @(negedge clk) reset = 1'b1;
      repeat (3) tick();
      for (int a = 'h10; a <= 'h21; a++) begin
         expect_val($sformatf("rd_%0h_after_reset", a), 32'h0);
         rd(AW'(a), d);
         obs_q.push_back({24'h0, d});
      end
      expect_val("rd_22_z", 32'hFF); rd(6'h22, d); obs_q.push_back({24'h0, d});
      expect_val("rd_0f_z", 32'hFF); rd(6'h0F, d); obs_q.push_back({24'h0, d});
      while (sb_q.size() > 0) begin
         exp_t e = sb_q.pop_front();
         logic [31:0] o = obs_q.pop_front();
         checks++;
         if (o !== e.val) $display("FAIL %s: got %0h required %0h", e.name, o, e.val);
         else passes++;
      end
   endtask

   task automatic test_output();
      logic [DW-1:0] d;
      pins_oe[15:8] = '0;
      wr(6'h14, 8'hFF);
      wr(6'h15, 8'hA5);
      expect_val("pins1_after_port_write", 32'hA5); obs_q.push_back({24'h0, pins[15:8]});
      tick(); tick();
      expect_val("pin1_two_edges_later", 32'hA5); rd(6'h13, d); obs_q.push_back({24'h0, d});
      wr(6'h13, 8'h0F);
      expect_val("port1_after_toggle", 32'hAA); rd(6'h15, d); obs_q.push_back({24'h0, d});
      expect_val("pins1_after_toggle", 32'hAA); obs_q.push_back({24'h0, pins[15:8]});
      expect_val("ddr1_readback", 32'hFF);      rd(6'h14, d); obs_q.push_back({24'h0, d});
      while (sb_q.size() > 0) begin
         exp_t e = sb_q.pop_front();
         logic [31:0] o = obs_q.pop_front();
         checks++;
         if (o !== e.val) $display("FAIL %s: got %0h required %0h", e.name, o, e.val);
         else passes++;
      end
   endtask

   task automatic test_input_irq();
      logic [DW-1:0] d;
      wr(6'h17, 8'h00);
      wr(6'h1E, 8'h01);
      wr(6'h21, 8'h04);
      pins_val[16] = 1'b1;
      tick();
      expect_val("pcifr_after_k", 32'h0);    rd(6'h20, d); obs_q.push_back({24'h0, d});
      tick();
      expect_val("pin2_after_k1", 32'h01);   rd(6'h16, d); obs_q.push_back({24'h0, d});
      expect_val("pcifr_after_k1", 32'h0);   rd(6'h20, d); obs_q.push_back({24'h0, d});
      expect_val("irq_after_k1", 32'h0);     obs_q.push_back({31'h0, irq});
      tick();
      expect_val("pcifr_after_k2", 32'h04);  rd(6'h20, d); obs_q.push_back({24'h0, d});
      expect_val("irq_after_k2", 32'h1);     obs_q.push_back({31'h0, irq});
      wr(6'h20, 8'h04);
      expect_val("pcifr_cleared", 32'h0);    rd(6'h20, d); obs_q.push_back({24'h0, d});
      expect_val("irq_cleared", 32'h0);      obs_q.push_back({31'h0, irq});
      pins_val[17] = 1'b1;
      repeat (4) tick();
      expect_val("pin2_unmasked_bit", 32'h03); rd(6'h16, d); obs_q.push_back({24'h0, d});
      expect_val("pcifr_unmasked", 32'h0);     rd(6'h20, d); obs_q.push_back({24'h0, d});
      expect_val("irq_unmasked", 32'h0);       obs_q.push_back({31'h0, irq});
      while (sb_q.size() > 0) begin
         exp_t e = sb_q.pop_front();
         logic [31:0] o = obs_q.pop_front();
         checks++;
         if (o !== e.val) $display("FAIL %s: got %0h required %0h", e.name, o, e.val);
         else passes++;
      end
   endtask

   task automatic test_w1c_collision();
      logic [DW-1:0] d;
      pins_val[16] = 1'b0;
      tick();
      tick();
      wr(6'h20, 8'h04);
      expect_val("pcifr_set_wins", 32'h04); rd(6'h20, d); obs_q.push_back({24'h0, d});
      expect_val("irq_set_wins", 32'h1);    obs_q.push_back({31'h0, irq});
      wr(6'h20, 8'h04);
      expect_val("pcifr_lone_w1c", 32'h0);  rd(6'h20, d); obs_q.push_back({24'h0, d});
      expect_val("irq_lone_w1c", 32'h0);    obs_q.push_back({31'h0, irq});
      while (sb_q.size() > 0) begin
         exp_t e = sb_q.pop_front();
         logic [31:0] o = obs_q.pop_front();
         checks++;
         if (o !== e.val) $display("FAIL %s: got %0h required %0h", e.name, o, e.val);
         else passes++;
      end
   endtask

   task automatic test_warmup();
      logic [DW-1:0] d;
      @(negedge clk) reset = 1'b0;
      #1;
      pins_val[7:0] = 8'hFF;
      cs = 1'b1; we = 1'b1; oe = 1'b0; address = 6'h1C; data_oe = 1'b1; data_val = 8'hFF;
      @(negedge clk) reset = 1'b1;
      tick();
      cs = 1'b0; we = 1'b0; data_oe = 1'b0;
      expect_val("pcifr_warm_edge1", 32'h0); rd(6'h20, d); obs_q.push_back({24'h0, d});
      tick();
      expect_val("pcifr_warm_edge2", 32'h0); rd(6'h20, d); obs_q.push_back({24'h0, d});
      tick();
      expect_val("pcifr_warm_edge3", 32'h0); rd(6'h20, d); obs_q.push_back({24'h0, d});
      tick(); tick();
      expect_val("pcifr_warm_edge5", 32'h0); rd(6'h20, d); obs_q.push_back({24'h0, d});
      expect_val("pcmsk0_readback", 32'hFF); rd(6'h1C, d); obs_q.push_back({24'h0, d});
      pins_val[0] = 1'b0;
      repeat (3) tick();
      expect_val("pcifr_after_warmup", 32'h01); rd(6'h20, d); obs_q.push_back({24'h0, d});
      while (sb_q.size() > 0) begin
         exp_t e = sb_q.pop_front();
         logic [31:0] o = obs_q.pop_front();
         checks++;
         if (o !== e.val) $display("FAIL %s: got %0h required %0h", e.name, o, e.val);
         else passes++;
      end
   endtask

   task automatic test_reset_mid();
      logic [DW-1:0] d;
      pins_oe[31:24] = '0;
      wr(6'h21, 8'h01);
      wr(6'h1A, 8'hFF);
      wr(6'h1B, 8'h3C);
      expect_val("pins3_driven", 32'h3C); obs_q.push_back({24'h0, pins[31:24]});
      expect_val("irq_before_reset", 32'h1); obs_q.push_back({31'h0, irq});
      @(negedge clk) reset = 1'b0;
      #1;
      expect_val("irq_async_reset", 32'h0);  obs_q.push_back({31'h0, irq});
      expect_val("pins3_z_async", 32'hFF);   obs_q.push_back({24'h0, pins[31:24]});
      expect_val("pcifr_async", 32'h0);      rd(6'h20, d); obs_q.push_back({24'h0, d});
      expect_val("ddr3_async", 32'h0);       rd(6'h1A, d); obs_q.push_back({24'h0, d});
      while (sb_q.size() > 0) begin
         exp_t e = sb_q.pop_front();
         logic [31:0] o = obs_q.pop_front();
         checks++;
         if (o !== e.val) $display("FAIL %s: got %0h required %0h", e.name, o, e.val);
         else passes++;
      end
      @(negedge clk) reset = 1'b1;
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: time %0t reached, required finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      cs = 1'b0; we = 1'b0; oe = 1'b0; address = '0;
      data_oe = 1'b0; data_val = '0;
      pins_oe = '0; pins_val = '0;
      reset = 1'b0;
      test_reset();
      test_output();
      test_input_irq();
      test_w1c_collision();
      test_warmup();
      test_reset_mid();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/io_port_bank.md
# io_port_bank

Parametrised general-purpose I/O peripheral on the CPU's I/O bus, the successor to the fixed two-port `pa`/`pb` arrangement. It supports `PORT_COUNT` ports, each with a direction register, an output register and a synchronised pin-input register. It adds per-port pin-change detection with mask, flag and enable registers, and a single interrupt request line. It sits beside the I/O register file and decodes its own address window, so the control unit's `io_cs`/`io_we`/`io_oe` bus signals drive it unchanged.

## Interface
- `DATA_WIDTH`, 8: bits per port and bus data width.
- `IO_ADDR_WIDTH`, 6: I/O address width.
- `PORT_COUNT`, 4: number of ports, 1..8.
- `BASE_ADDR`, 6'h10: first address of the window. Elaboration error if `BASE_ADDR+3*PORT_COUNT+PORT_COUNT+1 >= 2**IO_ADDR_WIDTH`.
- `SYNC_STAGES`, 2: input synchroniser depth, 2..4.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `cs` in 1: bus chip select.
- `we` in 1: write enable.
- `oe` in 1: output enable for reads.
- `address` in `IO_ADDR_WIDTH`: register address.
- `data` inout `DATA_WIDTH`: bidirectional bus data.
- `pins` inout `PORT_COUNT*DATA_WIDTH`: port p occupies bits [p*DATA_WIDTH +: DATA_WIDTH].
- `irq` out 1: pin-change interrupt request.

## Operation
Register map, with p = 0..PORT_COUNT-1 and offsets from `BASE_ADDR`:
- 3p = PINp. Read returns the synchronised pin value. Writing 1s toggles the matching PORTp bits (PORTp ^= data); writing 0s has no effect.
- 3p+1 = DDRp, read/write. Bit=1 means output.
- 3p+2 = PORTp, read/write.
- 3*PORT_COUNT+p = PCMSKp, read/write pin-change mask.
- 4*PORT_COUNT = PCIFR, flags in bits [PORT_COUNT-1:0]. Writing 1 clears a flag (W1C). Upper bits read 0.
- 4*PORT_COUNT+1 = PCICR, per-port enable in bits [PORT_COUNT-1:0]. Upper bits read 0 and writes to them are ignored.

Bus access:
- Write: when `cs & we` at a rising edge and the address is inside the window.
- Read: when `cs & oe & ~we` and the address is inside the window, `data` is driven combinationally with the addressed register. Otherwise `data` is high-Z.
- Out-of-window addresses: reads leave `data` high-Z; writes are ignored.

Pin drivers:
- Per bit, `pins` = PORT bit when DDR bit=1, else Z.
- The synchroniser input is always the `pins` net, so PINp of an output bit reflects the driven value.

Synchroniser and pin-change detection:
- Each pin passes through `SYNC_STAGES` flops; the last stage is PINp.
- A `prev` register holds PINp from the previous cycle.
- Change vector: `chg_p = (PINp ^ prev_p) & PCMSKp`.
- If `|chg_p` is true at an edge, PCIFR[p] is set at that edge.
- If a set and a W1C clear of the same flag land on the same edge, set wins.
- `irq = |(PCIFR & PCICR)`, combinational from registers.

Warm-up:
- A counter disables flag setting for the first `SYNC_STAGES+1` rising edges after reset deassertion. This prevents false events from the zero-initialised synchroniser.
- The counter saturates after warm-up and then has no further effect.

## Timing
Reset (`reset`=0, asynchronous):
- DDR, PORT, PCMSK, PCIFR, PCICR, synchroniser, `prev` and the warm-up counter all go to 0.
- `pins` all Z, `data` Z, `irq`=0.
- Reset asserted mid-operation clears everything immediately, including pending flags.

Register-write latency:
- A write at edge T updates the register after edge T.
- The `pins` output follows after edge T with no further delay.
- The PIN toggle takes effect after edge T.

Input latency (`SYNC_STAGES`=S), for an input stable before edge k:
- PINp updates after edge k+S-1.
- PCIFR[p] sets after edge k+S.
- `irq` rises in the same cycle as PCIFR[p], if PCICR[p] is set.

Other timing rules:
- Glitches shorter than one clock may be missed; this is acceptable.
- Simultaneous changes on several ports set all of the corresponding flags on the same edge.
- Reads have zero-cycle latency.
- A read and a write to the same register cannot coincide because `we` gates the read.

## Test plan
All scenarios use PORT_COUNT=4, BASE_ADDR=0x10, S=2.

1. Reset then read-back.
   - Stimulus: read all addresses 0x10..0x21.
   - Required: every in-window read returns 0x00, `pins` is Z, `irq`=0.
   - Stimulus: read address 0x22.
   - Required: `data` is Z.
2. Output path.
   - Stimulus: write DDR1 (0x14)=0xFF, then PORT1 (0x15)=0xA5.
   - Required: `pins[15:8]`=0xA5 after that edge; PIN1 (0x13) reads 0xA5 two edges later.
   - Stimulus: write 0x0F to PIN1.
   - Required: PORT1 reads 0xAA.
3. Input and interrupt.
   - Stimulus: set DDR2=0, PCMSK2 (0x1E)=0x01, PCICR (0x21)=0x04; drive `pins[16]` from 0 to 1 before edge k.
   - Required: PIN2 reads 0x01 after edge k+1; PCIFR (0x20)=0x04 and `irq`=1 after edge k+2.
   - Stimulus: toggle `pins[17]`, which is unmasked.
   - Required: no flag change.
4. W1C versus set collision.
   - Stimulus: write 0x04 to PCIFR on the same edge that a new masked change on port 2 is detected.
   - Required: PCIFR[2] stays 1.
   - Stimulus: a subsequent lone W1C write of 0x04.
   - Required: PCIFR[2] clears and `irq` falls.
5. Warm-up suppression.
   - Stimulus: hold `pins[7:0]`=0xFF with PCMSK0=0xFF through reset release.
   - Required: PCIFR[0] stays 0 through edge 3 and after.
6. Reset mid-operation.
   - Stimulus: with `irq`=1 and DDR3=0xFF, assert `reset` between edges.
   - Required: `irq`=0 and `pins[31:24]`=Z immediately, without waiting for a clock edge.
